// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with sticky illegal flag and retire counter
module multicycle_control #(
  parameter int OPW         = 6,
  parameter int USE_READY   = 1,
  parameter int ENABLE_ADDI = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t cur, nxt;
  logic   is_sw;      // lw/sw selector remembered from DECODE for the MEMADR branch
  logic   ready;
  logic   retire;
  logic   upper_ok;
  logic [5:0] op6;
  logic   op_lw, op_sw, op_r, op_beq, op_j, op_addi, op_legal;

  assign ready = mem_ready | (USE_READY == 0);
  assign op6   = opcode[5:0];
  assign state = cur;

  // Bits above the 6-bit opcode field must be clear for any legal decode
  if (OPW > 6) begin : g_upper
    assign upper_ok = ~|opcode[OPW-1:6];
  end else begin : g_no_upper
    assign upper_ok = 1'b1;
  end

  assign op_lw    = upper_ok && (op6 == 6'b100011);
  assign op_sw    = upper_ok && (op6 == 6'b101011);
  assign op_r     = upper_ok && (op6 == 6'b000000);
  assign op_beq   = upper_ok && (op6 == 6'b000100);
  assign op_j     = upper_ok && (op6 == 6'b000010);
  assign op_addi  = upper_ok && (op6 == 6'b001000) && (ENABLE_ADDI != 0);
  assign op_legal = op_lw | op_sw | op_r | op_beq | op_j | op_addi;

  // State register, sticky illegal flag and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= S_FETCH;
      is_sw       <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) begin
        is_sw <= op_sw;
        if (!op_legal) illegal <= 1'b1;
      end
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Next-state logic, Moore output decode and retire detection
  always_comb begin
    nxt           = S_FETCH;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (cur)
      S_FETCH: begin
        nxt       = ready ? S_DECODE : S_FETCH;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ready;
        pc_write  = ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (op_lw || op_sw) nxt = S_MEMADR;
        else if (op_r)      nxt = S_EXEC;
        else if (op_beq)    nxt = S_BRANCH;
        else if (op_j)      nxt = S_JUMP;
        else if (op_addi)   nxt = S_ADDIEX;
        else                nxt = S_FETCH;
      end
      S_MEMADR: begin
        nxt       = is_sw ? S_MEMWR : S_MEMRD;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        nxt      = ready ? S_MEMWB : S_MEMRD;
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        retire     = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        nxt       = ready ? S_FETCH : S_MEMWR;
        retire    = ready;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        nxt       = S_RWB;
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        retire    = 1'b1;
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        retire        = 1'b1;
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        retire    = 1'b1;
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDIEX: begin
        nxt       = S_ADDIWB;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        retire    = 1'b1;
        reg_write = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
    // Architectural side effects are blocked while reset is held
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      mem_read      = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst, mem_ready;
  logic [5:0]  opcode;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
  logic        ir_write, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [15:0] instr_count;

  // No-ready, no-addi, 2-bit counter instance
  logic        rst2, mem_ready2;
  logic [5:0]  opcode2;
  logic        pc_write2, pc_write_cond2, i_or_d2, mem_read2, mem_write2, mem_to_reg2;
  logic        ir_write2, reg_dst2, reg_write2, alu_src_a22, illegal2;
  logic [1:0]  alu_src_b2, alu_op2, pc_source2;
  logic [3:0]  state2;
  logic [1:0]  instr_count2;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal(illegal),
    .instr_count(instr_count)
  );

  multicycle_control #(.OPW(6), .USE_READY(0), .ENABLE_ADDI(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .opcode(opcode2), .mem_ready(mem_ready2),
    .pc_write(pc_write2), .pc_write_cond(pc_write_cond2), .i_or_d(i_or_d2),
    .mem_read(mem_read2), .mem_write(mem_write2), .mem_to_reg(mem_to_reg2),
    .ir_write(ir_write2), .reg_dst(reg_dst2), .reg_write(reg_write2),
    .alu_src_a(alu_src_a22), .alu_src_b(alu_src_b2), .alu_op(alu_op2),
    .pc_source(pc_source2), .state(state2), .illegal(illegal2),
    .instr_count(instr_count2)
  );

  typedef struct {
    logic [3:0]  st;
    logic        rdy;
    logic [15:0] cnt;
  } ent_t;

  ent_t        sb[$];
  ent_t        e;
  logic [15:0] exp_cnt;
  logic [1:0]  exp_cnt2;
  int          n_checks = 0;
  int          n_pass   = 0;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MW = 4'd5;
  localparam logic [3:0] EX = 4'd6, RWB = 4'd7, BR = 4'd8, JP = 4'd9, AE = 4'd10, AW = 4'd11;

  task automatic push(input logic [3:0] st, input logic rdy);
    ent_t t;
    t.st  = st;
    t.rdy = rdy;
    t.cnt = exp_cnt;
    sb.push_back(t);
  endtask

  task automatic push2(input logic [3:0] st);
    ent_t t;
    t.st  = st;
    t.rdy = 1'b0;
    t.cnt = {14'd0, exp_cnt2};
    sb.push_back(t);
  endtask

  task test_reset;
    rst = 1'b1; rst2 = 1'b1; mem_ready = 1'b1; mem_ready2 = 1'b0;
    opcode = 6'b100011; opcode2 = 6'b111111;
    exp_cnt = '0; exp_cnt2 = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (state !== F || illegal !== 1'b0 || instr_count !== 16'd0)
      $display("FAIL reset_state: state=%0d illegal=%0d cnt=%0d, want 0/0/0", state, illegal, instr_count);
    else n_pass++;
    n_checks++;
    if (mem_read !== 1'b0 || ir_write !== 1'b0 || pc_write !== 1'b0)
      $display("FAIL reset_strobes: mem_read=%0d ir_write=%0d pc_write=%0d, want 0/0/0", mem_read, ir_write, pc_write);
    else n_pass++;
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    n_checks++;
    if (mem_read !== 1'b1 || ir_write !== 1'b0 || alu_src_b !== 2'b01)
      $display("FAIL fetch_after_reset: mem_read=%0d ir_write=%0d alu_src_b=%0d, want 1/0/1", mem_read, ir_write, alu_src_b);
    else n_pass++;
  endtask

  task test_fetch_hold;
    opcode = 6'b000000;
    push(F, 1'b0); push(F, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); mem_ready = e.rdy; #1;
      n_checks++;
      if (state !== e.st || instr_count !== e.cnt || ir_write !== e.rdy || pc_write !== e.rdy)
        $display("FAIL fetch_hold: state=%0d cnt=%0d ir=%0d pc=%0d, want %0d/%0d/%0d/%0d", state, instr_count, ir_write, pc_write, e.st, e.cnt, e.rdy, e.rdy);
      else n_pass++;
    end
    push(D, 1'b1); push(EX, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); mem_ready = e.rdy; #1;
      n_checks++;
      if (state !== e.st || instr_count !== e.cnt)
        $display("FAIL rtype_seq: state=%0d cnt=%0d, want %0d/%0d", state, instr_count, e.st, e.cnt);
      else n_pass++;
    end
    n_checks++;
    if (alu_src_a !== 1'b1 || alu_op !== 2'b10)
      $display("FAIL exec_outputs: alu_src_a=%0d alu_op=%0d, want 1/2", alu_src_a, alu_op);
    else n_pass++;
    push(RWB, 1'b1);
    e = sb.pop_front(); @(negedge clk); mem_ready = e.rdy; #1;
    n_checks++;
    if (state !== e.st || reg_dst !== 1'b1 || reg_write !== 1'b1)
      $display("FAIL rwb_outputs: state=%0d reg_dst=%0d reg_write=%0d, want %0d/1/1", state, reg_dst, reg_write, e.st);
    else n_pass++;
    exp_cnt++;
  endtask

  task test_lw;
    opcode = 6'b100011;
    push(F, 1'b1); push(D, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); mem_ready = e.rdy; #1;
      n_checks++;
      if (state !== e.st || instr_count !== e.cnt)
        $display("FAIL lw_seq: state=%0d cnt=%0d, want %0d/%0d", state, instr_count, e.st, e.cnt);
      else n_pass++;
    end
    n_checks++;
    if (alu_src_b !== 2'b11) $display("FAIL decode_alu_src_b: got %0d want 3", alu_src_b);
    else n_pass++;
    push(MA, 1'b1); push(MR, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); mem_ready = e.rdy; #1;
      n_checks++;
      if (state !== e.st || instr_count !== e.cnt)
        $display("FAIL lw_seq: state=%0d cnt=%0d, want %0d/%0d", state, instr_count, e.st, e.cnt);
      else n_pass++;
    end
    n_checks++;
    if (mem_read !== 1'b1 || i_or_d !== 1'b1)
      $display("FAIL memrd_outputs: mem_read=%0d i_or_d=%0d, want 1/1", mem_read, i_or_d);
    else n_pass++;
    push(MWB, 1'b1);
    e = sb.pop_front(); @(negedge clk); mem_ready = e.rdy; #1;
    n_checks++;
    if (state !== e.st || instr_count !== e.cnt || reg_write !== 1'b1 || mem_to_reg !== 1'b1)
      $display("FAIL memwb: state=%0d cnt=%0d reg_write=%0d mem_to_reg=%0d, want %0d/%0d/1/1", state, instr_count, reg_write, mem_to_reg, e.st, e.cnt);
    else n_pass++;
    exp_cnt++;
  endtask

  task test_sw_wait;
    opcode = 6'b101011;
    push(F, 1'b1); push(D, 1'b1); push(MA, 1'b1);
    push(MW, 1'b0); push(MW, 1'b0); push(MW, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); mem_ready = e.rdy; #1;
      n_checks++;
      if (state !== e.st || instr_count !== e.cnt || (e.st == MW && (mem_write !== 1'b1 || i_or_d !== 1'b1)))
        $display("FAIL sw_wait: state=%0d cnt=%0d mem_write=%0d, want %0d/%0d", state, instr_count, mem_write, e.st, e.cnt);
      else n_pass++;
    end
    exp_cnt++;
  endtask

  task test_beq_j;
    opcode = 6'b000100;
    push(F, 1'b1); push(D, 1'b1); push(BR, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); mem_ready = e.rdy; #1;
      n_checks++;
      if (state !== e.st || instr_count !== e.cnt)
        $display("FAIL beq_seq: state=%0d cnt=%0d, want %0d/%0d", state, instr_count, e.st, e.cnt);
      else n_pass++;
    end
    n_checks++;
    if (pc_write_cond !== 1'b1 || pc_source !== 2'b01 || alu_op !== 2'b01 || pc_write !== 1'b0)
      $display("FAIL branch_outputs: pwc=%0d src=%0d op=%0d pw=%0d, want 1/1/1/0", pc_write_cond, pc_source, alu_op, pc_write);
    else n_pass++;
    exp_cnt++;
    opcode = 6'b000010;
    push(F, 1'b1); push(D, 1'b1); push(JP, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); mem_ready = e.rdy; #1;
      n_checks++;
      if (state !== e.st || instr_count !== e.cnt)
        $display("FAIL j_seq: state=%0d cnt=%0d, want %0d/%0d", state, instr_count, e.st, e.cnt);
      else n_pass++;
    end
    n_checks++;
    if (pc_write !== 1'b1 || pc_source !== 2'b10)
      $display("FAIL jump_outputs: pc_write=%0d pc_source=%0d, want 1/2", pc_write, pc_source);
    else n_pass++;
    exp_cnt++;
  endtask

  task test_addi;
    opcode = 6'b001000;
    push(F, 1'b1); push(D, 1'b1); push(AE, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); mem_ready = e.rdy; #1;
      n_checks++;
      if (state !== e.st || instr_count !== e.cnt)
        $display("FAIL addi_seq: state=%0d cnt=%0d, want %0d/%0d", state, instr_count, e.st, e.cnt);
      else n_pass++;
    end
    n_checks++;
    if (alu_src_a !== 1'b1 || alu_src_b !== 2'b10)
      $display("FAIL addiex_outputs: alu_src_a=%0d alu_src_b=%0d, want 1/2", alu_src_a, alu_src_b);
    else n_pass++;
    push(AW, 1'b1);
    e = sb.pop_front(); @(negedge clk); mem_ready = e.rdy; #1;
    n_checks++;
    if (state !== e.st || reg_write !== 1'b1 || reg_dst !== 1'b0)
      $display("FAIL addiwb_outputs: state=%0d reg_write=%0d reg_dst=%0d, want %0d/1/0", state, reg_write, reg_dst, e.st);
    else n_pass++;
    exp_cnt++;
  endtask

  task test_illegal;
    opcode = 6'b111111;
    push(F, 1'b1); push(D, 1'b1); push(F, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); mem_ready = e.rdy; #1;
      n_checks++;
      if (state !== e.st || instr_count !== e.cnt)
        $display("FAIL illegal_seq: state=%0d cnt=%0d, want %0d/%0d", state, instr_count, e.st, e.cnt);
      else n_pass++;
    end
    n_checks++;
    if (illegal !== 1'b1) $display("FAIL illegal_set: got %0d want 1", illegal);
    else n_pass++;
    opcode = 6'b000100;
    push(D, 1'b1); push(BR, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); mem_ready = e.rdy; #1;
      n_checks++;
      if (state !== e.st || instr_count !== e.cnt)
        $display("FAIL illegal_follow: state=%0d cnt=%0d, want %0d/%0d", state, instr_count, e.st, e.cnt);
      else n_pass++;
    end
    n_checks++;
    if (illegal !== 1'b1) $display("FAIL illegal_sticky: got %0d want 1", illegal);
    else n_pass++;
    exp_cnt++;
  endtask

  task test_reset_midwait;
    opcode = 6'b100011;
    push(F, 1'b1); push(D, 1'b1); push(MA, 1'b1); push(MR, 1'b0); push(MR, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); mem_ready = e.rdy; #1;
      n_checks++;
      if (state !== e.st || instr_count !== e.cnt || (e.st == MR && mem_read !== 1'b1))
        $display("FAIL midwait_seq: state=%0d cnt=%0d mem_read=%0d, want %0d/%0d", state, instr_count, mem_read, e.st, e.cnt);
      else n_pass++;
    end
    @(negedge clk); rst = 1'b1; mem_ready = 1'b0; #1;
    n_checks++;
    if (state !== MR || mem_read !== 1'b0)
      $display("FAIL rst_force_mem_read: state=%0d mem_read=%0d, want 3/0", state, mem_read);
    else n_pass++;
    @(negedge clk); rst = 1'b0; mem_ready = 1'b1; #1;
    n_checks++;
    if (state !== F || instr_count !== 16'd0 || illegal !== 1'b0)
      $display("FAIL rst_midwait: state=%0d cnt=%0d illegal=%0d, want 0/0/0", state, instr_count, illegal);
    else n_pass++;
    exp_cnt = '0;
  endtask

  task test_addi_disabled;
    opcode2 = 6'b001000;
    @(negedge clk); rst2 = 1'b0; #1;
    n_checks++;
    if (state2 !== F || illegal2 !== 1'b0)
      $display("FAIL dut2_release: state=%0d illegal=%0d, want 0/0", state2, illegal2);
    else n_pass++;
    push2(D); push2(F);
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); #1;
      n_checks++;
      if (state2 !== e.st || instr_count2 !== e.cnt[1:0])
        $display("FAIL addi_disabled_seq: state=%0d cnt=%0d, want %0d/%0d", state2, instr_count2, e.st, e.cnt);
      else n_pass++;
    end
    n_checks++;
    if (illegal2 !== 1'b1) $display("FAIL addi_disabled_illegal: got %0d want 1", illegal2);
    else n_pass++;
  endtask

  task test_count_wrap;
    int wrap_tbl[5] = '{1, 2, 3, 0, 1};
    opcode2 = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      push2(D); push2(EX); push2(RWB);
      exp_cnt2++;
      push2(F);
      while (sb.size() > 0) begin
        e = sb.pop_front(); @(negedge clk); #1;
        n_checks++;
        if (state2 !== e.st || instr_count2 !== e.cnt[1:0])
          $display("FAIL wrap_seq: state=%0d cnt=%0d, want %0d/%0d", state2, instr_count2, e.st, e.cnt);
        else n_pass++;
      end
      n_checks++;
      if (instr_count2 !== wrap_tbl[i][1:0])
        $display("FAIL wrap_count[%0d]: got %0d want %0d", i, instr_count2, wrap_tbl[i]);
      else n_pass++;
    end
    n_checks++;
    if (illegal2 !== 1'b1) $display("FAIL dut2_illegal_held: got %0d want 1", illegal2);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_fetch_hold;
    test_lw;
    test_sw_wait;
    test_beq_j;
    test_addi;
    test_illegal;
    test_reset_midwait;
    test_addi_disabled;
    test_count_wrap;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
